// File: rtl/sparse_rle_encoder_pkg.sv
`default_nettype none
// sparse_rle_encoder_pkg: types and defaults shared by the PE sparse detector and the RLE encoder.
// Rev 1.0
package sparse_rle_encoder_pkg;

  localparam logic [15:0] SPARSITY_THRESHOLD_DEFAULT = 16'h0010;
  localparam int          TOKEN_DATA_WIDTH           = 16;
  localparam int          TOKEN_RUN_WIDTH            = 4;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_ACCUM = 1'b1
  } state_e;

  typedef struct packed {
    logic [TOKEN_DATA_WIDTH-1:0] data;
    logic [TOKEN_RUN_WIDTH-1:0]  run;
    logic                        last;
  } token_t;

endpackage : sparse_rle_encoder_pkg
`default_nettype wire

// File: rtl/sparse_rle_encoder_classify.sv
`default_nettype none
// sparse_classify: combinational magnitude-below-threshold test for signed elements.
// Rev 1.0
module sparse_classify #(
  parameter int                    DATA_WIDTH         = 16,
  parameter logic [DATA_WIDTH-1:0] SPARSITY_THRESHOLD = DATA_WIDTH'(16'h0010)
) (
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_sparse
);

  logic [DATA_WIDTH-1:0] w_abs;

  // The most negative value negates to itself and reads as a large unsigned magnitude.
  assign w_abs    = i_data[DATA_WIDTH-1] ? (-i_data) : i_data;
  assign o_sparse = (w_abs < SPARSITY_THRESHOLD) || (i_data == '0);

endmodule : sparse_classify
`default_nettype wire

// File: rtl/sparse_rle_encoder.sv
`default_nettype none
// sparse_rle_encoder: turns a dense signed element stream into {data, zero-run, last} tokens.
// Rev 1.0
module sparse_rle_encoder
  import sparse_rle_encoder_pkg::*;
#(
  parameter int                    DATA_WIDTH         = 16,
  parameter int                    RUN_WIDTH          = 4,
  parameter logic [DATA_WIDTH-1:0] SPARSITY_THRESHOLD = DATA_WIDTH'(SPARSITY_THRESHOLD_DEFAULT)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [RUN_WIDTH-1:0]  out_run,
  output logic                  out_last,
  output logic                  frame_done,
  output logic [15:0]           sparse_count,
  output logic [15:0]           token_count
);

  localparam logic [RUN_WIDTH-1:0] c_MAX_RUN = '1;

  state_e                r_state;
  logic [RUN_WIDTH-1:0]  r_run;
  logic                  r_out_valid;
  logic [DATA_WIDTH-1:0] r_out_data;
  logic [RUN_WIDTH-1:0]  r_out_run;
  logic                  r_out_last;
  logic                  r_frame_done;
  logic [15:0]           r_sparse_count;
  logic [15:0]           r_token_count;

  logic                  w_sparse;
  logic                  w_accept;
  logic                  w_xfer;
  logic                  w_emit;
  logic [RUN_WIDTH-1:0]  w_run_cur;

  sparse_classify #(
    .DATA_WIDTH         (DATA_WIDTH),
    .SPARSITY_THRESHOLD (SPARSITY_THRESHOLD)
  ) u_classify (
    .i_data   (in_data),
    .o_sparse (w_sparse)
  );

  assign in_ready  = !r_out_valid || out_ready;
  assign w_accept  = in_valid && in_ready;
  assign w_xfer    = r_out_valid && out_ready;
  // No run can be pending outside an open frame.
  assign w_run_cur = (r_state == ST_IDLE) ? '0 : r_run;
  assign w_emit    = w_accept && (!w_sparse || in_last || (w_run_cur == c_MAX_RUN));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= ST_IDLE;
      r_run          <= '0;
      r_out_valid    <= 1'b0;
      r_out_data     <= '0;
      r_out_run      <= '0;
      r_out_last     <= 1'b0;
      r_frame_done   <= 1'b0;
      r_sparse_count <= '0;
      r_token_count  <= '0;
    end else begin
      r_frame_done <= w_xfer && r_out_last;
      if (w_xfer) begin
        r_token_count <= r_token_count + 16'd1;
      end
      if (w_accept) begin
        r_state <= in_last ? ST_IDLE : ST_ACCUM;
        r_run   <= w_emit ? '0 : (w_run_cur + RUN_WIDTH'(1));
        if (w_sparse) begin
          r_sparse_count <= r_sparse_count + 16'd1;
        end
      end
      if (w_emit) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_sparse ? '0 : in_data;
        r_out_run   <= w_run_cur;
        r_out_last  <= in_last;
      end else if (w_xfer) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid    = r_out_valid;
  assign out_data     = r_out_data;
  assign out_run      = r_out_run;
  assign out_last     = r_out_last;
  assign frame_done   = r_frame_done;
  assign sparse_count = r_sparse_count;
  assign token_count  = r_token_count;

endmodule : sparse_rle_encoder
`default_nettype wire

// File: tb/tb_sparse_rle_encoder.sv
`default_nettype none
// tb_sparse_rle_encoder: directed and randomized checks against a token-stream reference model.
// Rev 1.0
module tb_sparse_rle_encoder;

  localparam int c_THR     = 16;
  localparam int c_MAX_RUN = 15;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = 16'h0;
  logic        in_last = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_data;
  logic [3:0]  out_run;
  logic        out_last;
  logic        frame_done;
  logic [15:0] sparse_count;
  logic [15:0] token_count;

  int checks = 0;
  int errors = 0;

  sparse_rle_encoder dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_last      (in_last),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_run      (out_run),
    .out_last     (out_last),
    .frame_done   (frame_done),
    .sparse_count (sparse_count),
    .token_count  (token_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit is_sparse(input logic [15:0] d);
    int v;
    int m;
    v = int'($signed(d));
    m = (v < 0) ? -v : v;
    return m < c_THR;
  endfunction

  // Reference model state: expected token queue, pending zero count, counters.
  logic [20:0] expq[$];
  logic [20:0] seen[$];
  int          m_zeros = 0;
  logic        m_valid = 1'b0;
  logic        m_fd = 1'b0;
  logic [15:0] m_sparse = 16'h0;
  logic [15:0] m_tok = 16'h0;
  int          fd_pulses = 0;
  bit          mon_en = 1'b0;
  logic        p_stall = 1'b0;
  logic [20:0] p_tok = 21'h0;

  always @(negedge clk) begin : mon
    logic        acc;
    logic        xfer;
    logic        sp;
    logic        emit;
    logic [20:0] cur;
    logic [20:0] exp_tok;
    cur = {out_data, out_run, out_last};
    if (rst) begin
      expq.delete();
      m_zeros  = 0;
      m_valid  = 1'b0;
      m_fd     = 1'b0;
      m_sparse = 16'h0;
      m_tok    = 16'h0;
      p_stall  = 1'b0;
    end else if (mon_en) begin
      chk("in_ready", 32'(in_ready), 32'(!out_valid || out_ready));
      chk("out_valid", 32'(out_valid), 32'(m_valid));
      chk("frame_done", 32'(frame_done), 32'(m_fd));
      chk("sparse_count", 32'(sparse_count), 32'(m_sparse));
      chk("token_count", 32'(token_count), 32'(m_tok));
      if (frame_done) fd_pulses++;
      if (p_stall) chk("stall_stable", 32'(cur), 32'(p_tok));
      xfer = out_valid && out_ready;
      if (xfer) begin
        seen.push_back(cur);
        if (expq.size() == 0) begin
          chk("unexpected_token", 32'(cur), 32'h1FFFFFF);
        end else begin
          exp_tok = expq.pop_front();
          chk("token", 32'(cur), 32'(exp_tok));
        end
      end
      acc  = in_valid && in_ready;
      sp   = is_sparse(in_data);
      emit = 1'b0;
      if (acc) begin
        if (sp) m_sparse = m_sparse + 16'd1;
        if (!sp || in_last || m_zeros == c_MAX_RUN) begin
          expq.push_back({sp ? 16'h0 : in_data, 4'(m_zeros), in_last});
          m_zeros = 0;
          emit    = 1'b1;
        end else begin
          m_zeros++;
        end
      end
      m_valid = emit ? 1'b1 : (xfer ? 1'b0 : m_valid);
      m_fd    = xfer && out_last;
      if (xfer) m_tok = m_tok + 16'd1;
      p_stall = out_valid && !out_ready;
      p_tok   = cur;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic send(input logic [15:0] d, input logic l);
    int n;
    n        = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready stuck at 0 for data 0x%0h", d);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic chk_seen(input string nm, input int idx, input logic [20:0] exp);
    if (idx < seen.size()) chk(nm, 32'(seen[idx]), 32'(exp));
    else chk(nm, 32'h1FFFFFF, 32'(exp));
  endtask

  initial begin
    logic [15:0] pick[5];
    pick = '{16'hFFF0, 16'hFFF1, 16'h0010, 16'h000F, 16'h8000};

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst    = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_counts", {sparse_count, token_count}, 32'h0);
    chk("rst_in_ready", 32'(in_ready), 32'h1);
    chk("rst_state", 32'(dut.r_state), 32'h0);
    @(posedge clk);
    #1;

    // Basic frame
    seen.delete();
    fd_pulses = 0;
    send(16'h0100, 1'b0);
    send(16'h0000, 1'b0);
    send(16'h0005, 1'b0);
    send(16'h0020, 1'b1);
    idle(3);
    chk("t1_ntok", 32'(seen.size()), 32'd2);
    chk_seen("t1_tok0", 0, {16'h0100, 4'd0, 1'b0});
    chk_seen("t1_tok1", 1, {16'h0020, 4'd2, 1'b1});
    chk("t1_fd_pulses", 32'(fd_pulses), 32'd1);
    chk("t1_sparse", 32'(sparse_count), 32'd2);
    chk("t1_tokens", 32'(token_count), 32'd2);

    // 17 zeros: escape after the 16th, closing token after the 17th
    do_reset();
    seen.delete();
    for (int i = 0; i < 17; i++) send(16'h0000, i == 16);
    idle(3);
    chk("t2_ntok", 32'(seen.size()), 32'd2);
    chk_seen("t2_escape", 0, {16'h0000, 4'd15, 1'b0});
    chk_seen("t2_close", 1, {16'h0000, 4'd0, 1'b1});
    chk("t2_sparse", 32'(sparse_count), 32'd17);

    // Threshold edges
    seen.delete();
    send(16'hFFF0, 1'b0);
    send(16'hFFF1, 1'b0);
    send(16'h8000, 1'b0);
    send(16'h0010, 1'b1);
    idle(3);
    chk("t3_ntok", 32'(seen.size()), 32'd3);
    chk_seen("t3_tok0", 0, {16'hFFF0, 4'd0, 1'b0});
    chk_seen("t3_tok1", 1, {16'h8000, 4'd1, 1'b0});
    chk_seen("t3_tok2", 2, {16'h0010, 4'd0, 1'b1});

    // Backpressure, then transfer and reload in one cycle
    out_ready = 1'b0;
    send(16'h0400, 1'b0);
    in_valid = 1'b1;
    in_data  = 16'h0500;
    in_last  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_in_ready", 32'(in_ready), 32'h0);
      chk("bp_hold", {out_data, 11'h0, out_run, out_valid}, {16'h0400, 11'h0, 4'd0, 1'b1});
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(16'h0500, 1'b1);
    @(negedge clk);
    chk("bp_reload", {out_data, 15'h0, out_valid}, {16'h0500, 15'h0, 1'b1});
    idle(3);

    // Reset mid-frame with a token pending
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(16'h0000, 1'b0);
    send(16'h0300, 1'b0);
    do_reset();
    @(negedge clk);
    chk("mr_out_valid", 32'(out_valid), 32'h0);
    chk("mr_counts", {sparse_count, token_count}, 32'h0);
    chk("mr_state", 32'(dut.r_state), 32'h0);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    seen.delete();
    send(16'h0200, 1'b1);
    idle(3);
    chk("mr_ntok", 32'(seen.size()), 32'd1);
    chk_seen("mr_tok", 0, {16'h0200, 4'd0, 1'b1});

    // Single sparse element with last in IDLE
    seen.delete();
    fd_pulses = 0;
    send(16'h0003, 1'b1);
    idle(3);
    chk_seen("single_tok", 0, {16'h0000, 4'd0, 1'b1});
    chk("single_fd", 32'(fd_pulses), 32'd1);
    chk("single_state", 32'(dut.r_state), 32'h0);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_last   = ($urandom_range(0, 15) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 3))
        0:       in_data = 16'h0000;
        1:       in_data = 16'($signed($urandom_range(0, 40)) - 20);
        2:       in_data = 16'($urandom);
        default: in_data = pick[$urandom_range(0, 4)];
      endcase
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    idle(5);
    chk("drain_empty", 32'(expq.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_sparse_rle_encoder
`default_nettype wire
